// File: rtl/avr_sram_bridge.sv
// Bridges an AVR 4-phase req/ack transaction onto an asynchronous SRAM with programmable
// wait states and a turnaround gap; owns both tri-state data buses and every SRAM strobe.
module avr_sram_bridge #(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 19,
    parameter int WAIT_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              avr_req,
    input  logic              avr_we,
    input  logic [AWIDTH-1:0] avr_addr,
    inout  wire  [DWIDTH-1:0] avr_data,
    output logic              avr_ack,
    output logic              busy,
    output logic [AWIDTH-1:0] sram_addr,
    inout  wire  [DWIDTH-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_ACKWAIT = 3'd4;
    localparam logic [2:0] ST_TURN    = 3'd5;

    // Counters only ever hold (N-1) down to 0, so they never need to wrap.
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int TCW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES - 1);
    localparam logic [TCW-1:0] TURN_LOAD = TCW'(TURN_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic              dir_q, dir_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wr_q, wr_d;
    logic [DWIDTH-1:0] rd_q, rd_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d;

    logic ack_q, ack_d;
    logic busy_q, busy_d;
    logic ce_n_q, ce_n_d;
    logic oe_n_q, oe_n_d;
    logic we_n_q, we_n_d;
    logic sram_drv_q, sram_drv_d;
    logic avr_drv_q, avr_drv_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (avr_req) begin
                    addr_d  = avr_addr;
                    dir_d   = avr_we;
                    if (avr_we) begin
                        wr_d = avr_data;
                    end
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wcnt_d  = WAIT_LOAD;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (wcnt_q == '0) begin
                    if (!dir_q) begin
                        rd_d = sram_data;
                    end
                    state_d = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_ACKWAIT;
            end
            ST_ACKWAIT: begin
                if (!avr_req) begin
                    tcnt_d  = TURN_LOAD;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                if (tcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - TCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every pin and bus enable is decoded from the next state so it can be registered
    // and still line up with the state it belongs to.
    always_comb begin
        ce_n_d     = !((state_d == ST_SETUP) || (state_d == ST_ACCESS) ||
                       (state_d == ST_HOLD)  || (state_d == ST_ACKWAIT));
        we_n_d     = !((state_d == ST_ACCESS) && dir_d);
        oe_n_d     = !((state_d == ST_ACCESS) && !dir_d);
        sram_drv_d = dir_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS) ||
                               (state_d == ST_HOLD));
        avr_drv_d  = !dir_d && (state_d == ST_ACKWAIT);
        ack_d      = (state_d == ST_ACKWAIT);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            addr_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            wcnt_q     <= '0;
            tcnt_q     <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            sram_drv_q <= 1'b0;
            avr_drv_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            sram_drv_q <= sram_drv_d;
            avr_drv_q  <= avr_drv_d;
        end
    end

    assign avr_ack   = ack_q;
    assign busy      = busy_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;

    assign sram_data = sram_drv_q ? wr_q : {DWIDTH{1'bz}};
    assign avr_data  = avr_drv_q  ? rd_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_avr_sram_bridge.sv
// Directed self-checking bench for avr_sram_bridge: one default instance (8-bit, 2 wait,
// 1 turn) and one re-parametrised instance (16-bit, 4 wait, 3 turn), each with an SRAM model.
module tb_avr_sram_bridge;

    localparam int AW = 19;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int viol_count   = 0;

    // Instance 0: DWIDTH=8, WAIT_CYCLES=2, TURN_CYCLES=1. Released buses float high.
    logic          req0 = 1'b0, we0 = 1'b0, en0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [7:0]    drv0 = '0;
    tri1  [7:0]    avr_data0, sram_data0;
    logic          ack0, busy0, ce0, oe0, wen0;
    logic [AW-1:0] saddr0;
    logic [7:0]    mem0 [0:255];

    // Instance 1: DWIDTH=16, WAIT_CYCLES=4, TURN_CYCLES=3.
    logic          req1 = 1'b0, we1 = 1'b0, en1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [15:0]   drv1 = '0;
    tri1  [15:0]   avr_data1, sram_data1;
    logic          ack1, busy1, ce1, oe1, wen1;
    logic [AW-1:0] saddr1;
    logic [15:0]   mem1 [0:255];

    avr_sram_bridge u_dut0 (
        .clk(clk), .reset(reset), .avr_req(req0), .avr_we(we0), .avr_addr(addr0),
        .avr_data(avr_data0), .avr_ack(ack0), .busy(busy0), .sram_addr(saddr0),
        .sram_data(sram_data0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(wen0)
    );

    avr_sram_bridge #(.DWIDTH(16), .AWIDTH(AW), .WAIT_CYCLES(4), .TURN_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .avr_req(req1), .avr_we(we1), .avr_addr(addr1),
        .avr_data(avr_data1), .avr_ack(ack1), .busy(busy1), .sram_addr(saddr1),
        .sram_data(sram_data1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(wen1)
    );

    // AVR-side drivers: the bench only drives avr_data while presenting write data.
    assign avr_data0 = en0 ? drv0 : 8'hzz;
    assign avr_data1 = en1 ? drv1 : 16'hzzzz;

    // SRAM models: drive on chip+output enable, store while write enable is low.
    assign sram_data0 = (!ce0 && !oe0) ? mem0[saddr0[7:0]] : 8'hzz;
    assign sram_data1 = (!ce1 && !oe1) ? mem1[saddr1[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 8'h00;
                mem1[i] <= 16'h0000;
            end
            mem0[8'hFF] <= 8'h3C;
        end else begin
            if (!ce0 && !wen0) mem0[saddr0[7:0]] <= sram_data0;
            if (!ce1 && !wen1) mem1[saddr1[7:0]] <= sram_data1;
        end
    end

    // Bus-ownership watchdog: strobe exclusivity, strobes only under chip enable,
    // nobody on sram_data while deselected, and bridge on avr_data only while acking.
    always @(negedge clk) begin
        if (!reset) begin
            if ((!wen0 && !oe0) || ((!wen0 || !oe0) && ce0) || (ce0 && sram_data0 !== 8'hFF) ||
                (!en0 && !ack0 && avr_data0 !== 8'hFF)) begin
                viol_count++;
                $display("[TB] FAIL contention0: ce_n=%b oe_n=%b we_n=%b sram=%h avr=%h ack=%b",
                         ce0, oe0, wen0, sram_data0, avr_data0, ack0);
            end
            if ((!wen1 && !oe1) || ((!wen1 || !oe1) && ce1) || (ce1 && sram_data1 !== 16'hFFFF) ||
                (!en1 && !ack1 && avr_data1 !== 16'hFFFF)) begin
                viol_count++;
                $display("[TB] FAIL contention1: ce_n=%b oe_n=%b we_n=%b sram=%h avr=%h ack=%b",
                         ce1, oe1, wen1, sram_data1, avr_data1, ack1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        tests_run++; if (ack0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack: got %b want 0", ack0); end
        tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy0); end
        tests_run++; if ({ce0, oe0, wen0} !== 3'b111) begin tests_failed++; $display("[TB] FAIL reset_strobes: got %b want 111", {ce0, oe0, wen0}); end
        tests_run++; if (saddr0 !== 19'h0) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h want 0", saddr0); end
        tests_run++; if (sram_data0 !== 8'hFF) begin tests_failed++; $display("[TB] FAIL reset_sram_z: got %h want ff", sram_data0); end
        tests_run++; if (avr_data0 !== 8'hFF) begin tests_failed++; $display("[TB] FAIL reset_avr_z: got %h want ff", avr_data0); end
        tests_run++; if ({ack1, busy1, ce1, oe1, wen1} !== 5'b00111) begin tests_failed++; $display("[TB] FAIL reset_inst1: got %b want 00111", {ack1, busy1, ce1, oe1, wen1}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int wl, bad;
        wl = 0; bad = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 19'h01234; drv0 = 8'hA5; en0 = 1'b1;
        tick();
        // Post-accept input changes must be ignored.
        en0 = 1'b0; we0 = 1'b0; addr0 = 19'h7FFFF; drv0 = 8'h00;
        tests_run++; if (saddr0 !== 19'h01234) begin tests_failed++; $display("[TB] FAIL wr_setup_addr: got %h want 01234", saddr0); end
        tests_run++; if ({ce0, oe0, wen0} !== 3'b011) begin tests_failed++; $display("[TB] FAIL wr_setup_strobes: got %b want 011", {ce0, oe0, wen0}); end
        tests_run++; if (sram_data0 !== 8'hA5) begin tests_failed++; $display("[TB] FAIL wr_setup_data: got %h want a5", sram_data0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!wen0) begin
                wl++;
                if (sram_data0 !== 8'hA5) bad++;
            end
        end
        tests_run++; if (wl !== 2) begin tests_failed++; $display("[TB] FAIL wr_we_len: got %0d want 2", wl); end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL wr_we_data: got %0d bad cycles want 0", bad); end
        tests_run++; if ({ce0, wen0, ack0} !== 3'b010) begin tests_failed++; $display("[TB] FAIL wr_hold_ctl: got %b want 010", {ce0, wen0, ack0}); end
        tests_run++; if (sram_data0 !== 8'hA5) begin tests_failed++; $display("[TB] FAIL wr_hold_data: got %h want a5", sram_data0); end
        tick();
        tests_run++; if (ack0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_ack_latency: got %b want 1", ack0); end
        tests_run++; if (sram_data0 !== 8'hFF) begin tests_failed++; $display("[TB] FAIL wr_ack_sram_z: got %h want ff", sram_data0); end
        req0 = 1'b0;
        tick();
        tests_run++; if ({ack0, busy0, ce0} !== 3'b011) begin tests_failed++; $display("[TB] FAIL wr_turn: got %b want 011", {ack0, busy0, ce0}); end
        tick();
        tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_idle: got %b want 0", busy0); end
        tests_run++; if (mem0[8'h34] !== 8'hA5) begin tests_failed++; $display("[TB] FAIL wr_mem: got %h want a5", mem0[8'h34]); end
    endtask

    task automatic test_read();
        int ol;
        ol = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 19'h000FF;
        tick();
        tests_run++; if ({ce0, oe0, wen0} !== 3'b011) begin tests_failed++; $display("[TB] FAIL rd_setup: got %b want 011", {ce0, oe0, wen0}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!oe0) ol++;
        end
        tests_run++; if (ol !== 2) begin tests_failed++; $display("[TB] FAIL rd_oe_len: got %0d want 2", ol); end
        tick();
        tests_run++; if (ack0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_ack: got %b want 1", ack0); end
        tests_run++; if (avr_data0 !== 8'h3C) begin tests_failed++; $display("[TB] FAIL rd_data: got %h want 3c", avr_data0); end
        tick();
        tests_run++; if ({ack0, avr_data0} !== {1'b1, 8'h3C}) begin tests_failed++; $display("[TB] FAIL rd_ack_hold: got %b/%h want 1/3c", ack0, avr_data0); end
        req0 = 1'b0;
        tick();
        tests_run++; if ({ack0, avr_data0} !== {1'b0, 8'hFF}) begin tests_failed++; $display("[TB] FAIL rd_release: got %b/%h want 0/ff", ack0, avr_data0); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 19'h00010; drv0 = 8'h5A; en0 = 1'b1;
        tick();
        en0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (ack0) break;
        end
        tests_run++; if (n !== 4) begin tests_failed++; $display("[TB] FAIL b2b_ack_ticks: got %0d want 4", n); end
        req0 = 1'b0;
        tick(); n++;
        req0 = 1'b1; we0 = 1'b0; addr0 = 19'h00010;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (!ce0) break;
        end
        // 4 + WAIT_CYCLES + TURN_CYCLES edges between consecutive accepts.
        tests_run++; if (n !== 7) begin tests_failed++; $display("[TB] FAIL b2b_accept_gap: got %0d want 7", n); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack0) break;
        end
        tests_run++; if ({ack0, avr_data0} !== {1'b1, 8'h5A}) begin tests_failed++; $display("[TB] FAIL b2b_readback: got %b/%h want 1/5a", ack0, avr_data0); end
        req0 = 1'b0;
        tick(); tick();
        tests_run++; if (viol_count !== 0) begin tests_failed++; $display("[TB] FAIL b2b_contention: got %0d want 0", viol_count); end
    endtask

    task automatic test_reset_abort();
        req0 = 1'b1; we0 = 1'b1; addr0 = 19'h00020; drv0 = 8'h77; en0 = 1'b1;
        tick();
        en0 = 1'b0;
        tick();
        tests_run++; if (wen0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_in_access: got %b want 0", wen0); end
        reset = 1'b1; req0 = 1'b0;
        tick();
        tests_run++; if ({wen0, ce0, busy0, ack0} !== 4'b1100) begin tests_failed++; $display("[TB] FAIL abort_ctl: got %b want 1100", {wen0, ce0, busy0, ack0}); end
        tests_run++; if (sram_data0 !== 8'hFF) begin tests_failed++; $display("[TB] FAIL abort_sram_z: got %h want ff", sram_data0); end
        reset = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 19'h000FF;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack0) break;
        end
        tests_run++; if ({ack0, avr_data0} !== {1'b1, 8'h3C}) begin tests_failed++; $display("[TB] FAIL abort_then_read: got %b/%h want 1/3c", ack0, avr_data0); end
        req0 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_req_pulse();
        int ol, ac, ack_at, busy_after;
        logic [7:0] seen;
        ol = 0; ac = 0; ack_at = -1; busy_after = 0; seen = 8'h00;
        req0 = 1'b1; we0 = 1'b0; addr0 = 19'h000FF;
        tick();
        req0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (!oe0) ol++;
            if (ack0) begin
                ac++;
                ack_at = i;
                seen = avr_data0;
            end
            if (i == 5) busy_after = busy0;
        end
        tests_run++; if (ol !== 2) begin tests_failed++; $display("[TB] FAIL pulse_oe_len: got %0d want 2", ol); end
        tests_run++; if (ac !== 1) begin tests_failed++; $display("[TB] FAIL pulse_ack_len: got %0d want 1", ac); end
        tests_run++; if (ack_at !== 4) begin tests_failed++; $display("[TB] FAIL pulse_ack_at: got %0d want 4", ack_at); end
        tests_run++; if (seen !== 8'h3C) begin tests_failed++; $display("[TB] FAIL pulse_data: got %h want 3c", seen); end
        tests_run++; if (busy_after !== 1) begin tests_failed++; $display("[TB] FAIL pulse_turn_busy: got %0d want 1", busy_after); end
        tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL pulse_idle: got %b want 0", busy0); end
    endtask

    task automatic test_param();
        int wl, bad, n, g, ol;
        wl = 0; bad = 0; n = 0; g = 0; ol = 0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 19'h00042; drv1 = 16'hBEEF; en1 = 1'b1;
        tick();
        en1 = 1'b0; n = 1;
        for (int i = 0; i < 30; i++) begin
            tick(); n++;
            if (!wen1) begin
                wl++;
                if (sram_data1 !== 16'hBEEF) bad++;
            end
            if (ack1) break;
        end
        tests_run++; if (wl !== 4) begin tests_failed++; $display("[TB] FAIL p16_we_len: got %0d want 4", wl); end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL p16_we_data: got %0d bad cycles want 0", bad); end
        tests_run++; if (n !== 7) begin tests_failed++; $display("[TB] FAIL p16_ack_cycle: got %0d want 7", n); end
        req1 = 1'b0;
        tick();
        tests_run++; if (ack1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL p16_ack_fall: got %b want 0", ack1); end
        req1 = 1'b1; we1 = 1'b0; addr1 = 19'h00042;
        for (int i = 0; i < 30; i++) begin
            tick(); g++;
            if (!ce1) break;
        end
        // Three TURN cycles plus the IDLE cycle that samples req.
        tests_run++; if (g !== 4) begin tests_failed++; $display("[TB] FAIL p16_turn_gap: got %0d want 4", g); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!oe1) ol++;
            if (ack1) break;
        end
        tests_run++; if (ol !== 4) begin tests_failed++; $display("[TB] FAIL p16_oe_len: got %0d want 4", ol); end
        tests_run++; if ({ack1, avr_data1} !== {1'b1, 16'hBEEF}) begin tests_failed++; $display("[TB] FAIL p16_readback: got %b/%h want 1/beef", ack1, avr_data1); end
        req1 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests_run++; if (busy1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL p16_idle: got %b want 0", busy1); end
        tests_run++; if (viol_count !== 0) begin tests_failed++; $display("[TB] FAIL final_contention: got %0d want 0", viol_count); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_req_pulse();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
